inst_fetch_queue: RTL and testbench
===================================

// Module: inst_fetch_queue
// PURPOSE
// - Front-end stage feeding the decoder: fetches 32-bit instructions from the memory controller at PC,
//   buffers them with their PC in a circular queue, presents the head to the decoder/dispatch stage.
// - Handles rollback (branch mispredict / jalr redirect) from the commit side by flushing and refetching.
// PARAMETERS
// - IQ_DEPTH   16          queue entries; power of two, >= 2
// - RESET_PC   32'h0       PC loaded at reset
// PORTS
// - clk              in   1    system clock
// - rst_n            in   1    asynchronous active-low reset
// - rdy              in   1    global enable; low = every register holds its value
// - fetch_req        out  1    request one instruction word at fetch_addr
// - fetch_addr       out  32   word-aligned fetch address
// - mem_inst_valid   in   1    response valid, one cycle pulse
// - mem_inst         in   32   fetched instruction
// - iq_valid         out  1    head entry valid (queue not empty)
// - iq_inst          out  32   head instruction, fed to decoder inst input
// - iq_pc            out  32   PC of head instruction
// - iq_pred_taken    out  1    predicted-taken flag of head (0 when predictor compiled out)
// - iq_pop           in   1    consumer accepts head this cycle; ignored when iq_valid=0
// - rollback_en      in   1    flush request
// - rollback_pc      in   32   redirect target
// BEHAVIOUR
// - Reset (async, rst_n=0): pc=RESET_PC, head=tail=count=0, state=IDLE, fetch_req=0,
//   fetch_addr=0, iq_valid=0, iq_inst=0, iq_pc=0, iq_pred_taken=0.
// - FSM: IDLE -> BUSY when count < IQ_DEPTH (fetch_req=1 for exactly one cycle, fetch_addr=pc).
//   BUSY -> IDLE on mem_inst_valid: push {mem_inst, pc, pred}; pc <= next_pc. At most one
//   request outstanding. DISCARD: waiting for a stale response; on mem_inst_valid drop it, -> IDLE.
// - Space check counts the outstanding request: issue only if count + (state!=IDLE) < IQ_DEPTH.
// - Head outputs are registered-free reads of entry[head]; valid the cycle after the push cycle.
// - Pop: iq_pop & iq_valid -> head++ mod IQ_DEPTH, count--. Push and pop same cycle -> count unchanged.
// - Full (count==IQ_DEPTH): no new request; a pop frees a slot, request may issue next cycle.
// - Pointers wrap modulo IQ_DEPTH; count is $clog2(IQ_DEPTH)+1 bits.
// - rollback_en (highest priority, overrides same-cycle push/pop): head=tail=count=0, pc=rollback_pc;
//   state BUSY -> DISCARD, IDLE stays IDLE, DISCARD stays DISCARD; a response arriving the same
//   cycle as rollback_en is dropped. Refetch from rollback_pc may issue the following cycle.
// - rdy=0: no state change, fetch_req forced 0, responses arriving while rdy=0 are not expected.
// CONFIGURATION
// - BRANCH_PREDICT_EN defined: static predecode of mem_inst at push: JAL -> pred=1, next_pc=pc+J-imm;
//   BR with imm[31]=1 (backward) -> pred=1, next_pc=pc+B-imm; else pred=0, next_pc=pc+4.
// - BRANCH_PREDICT_EN undefined: next_pc=pc+4 always, iq_pred_taken tied 0; JAL/branches resolved
//   downstream via rollback.
// STRUCTURE
// - Shared defines: INS_TYPE, ADDR_TYPE, OPCODE_RANGE, OPCODE_JAL, OPCODE_BR, ZERO_WORD, TRUE/FALSE,
//   plus new IQ state encodings (IQ_IDLE, IQ_BUSY, IQ_DISCARD) in defines.v.
// - One sub-module: static_predictor (combinational predecode + next_pc), instantiated only
//   under BRANCH_PREDICT_EN; queue storage and FSM stay in this module.
// TESTING
// - Reset then run with 1-cycle memory: fetch_addr sequence 0x0,0x4,0x8; iq_pc of first entry 0x0.
// - No pops, IQ_DEPTH=16: exactly 16 requests issued, then fetch_req stays 0; one pop -> one request.
// - Push and pop in the same cycle at count=5: count stays 5, head and tail both advance by 1.
// - rollback_en with request outstanding, rollback_pc=0x100: queue empty next cycle, stale
//   response dropped, next fetch_addr=0x100, first new iq_pc=0x100.
// - Predictor on: JAL at pc 0x20 with imm=+0x40 -> pred=1, next fetch 0x60; bne at 0x30 with
//   imm=-8 -> next fetch 0x28; forward beq imm=+16 -> next 0x34+... i.e. pc+4, pred=0.
// - rdy=0 for 3 cycles mid-BUSY: all outputs and pointers frozen; operation resumes on rdy=1.

Source files
------------

// File: rtl/inst_fetch_queue_pkg.sv
// Shared types and constants for the instruction fetch queue and its optional
// static predictor (enabled with the BRANCH_PREDICT_EN macro).
package inst_fetch_queue_pkg;

  typedef logic [31:0] ins_t;
  typedef logic [31:0] addr_t;

  localparam logic [31:0] ZERO_WORD  = 32'h0;
  localparam logic [6:0]  OPCODE_JAL = 7'b1101111;
  localparam logic [6:0]  OPCODE_BR  = 7'b1100011;

  typedef enum logic [1:0] {
    IQ_IDLE    = 2'd0,
    IQ_BUSY    = 2'd1,
    IQ_DISCARD = 2'd2
  } iq_state_e;

  function automatic logic [6:0] opcode_of(input ins_t inst);
    return inst[6:0];
  endfunction

  function automatic addr_t j_imm(input ins_t inst);
    return {{12{inst[31]}}, inst[19:12], inst[20], inst[30:21], 1'b0};
  endfunction

  function automatic addr_t b_imm(input ins_t inst);
    return {{20{inst[31]}}, inst[7], inst[30:25], inst[11:8], 1'b0};
  endfunction

endpackage

// File: rtl/inst_fetch_queue_if.sv
// Bundle of the fetch-queue buses: memory request/response, decoder head
// port and commit-side rollback. master = fetch queue, slave = its environment.
interface inst_fetch_queue_if;
  import inst_fetch_queue_pkg::*;

  logic  rdy;
  logic  fetch_req;
  addr_t fetch_addr;
  logic  mem_inst_valid;
  ins_t  mem_inst;
  logic  iq_valid;
  ins_t  iq_inst;
  addr_t iq_pc;
  logic  iq_pred_taken;
  logic  iq_pop;
  logic  rollback_en;
  addr_t rollback_pc;

  modport master (
    input  rdy, mem_inst_valid, mem_inst, iq_pop, rollback_en, rollback_pc,
    output fetch_req, fetch_addr, iq_valid, iq_inst, iq_pc, iq_pred_taken
  );

  modport slave (
    output rdy, mem_inst_valid, mem_inst, iq_pop, rollback_en, rollback_pc,
    input  fetch_req, fetch_addr, iq_valid, iq_inst, iq_pc, iq_pred_taken
  );

endinterface

// File: rtl/inst_fetch_queue_static_predictor.sv
// Combinational predecode: JAL and backward branches predicted taken.
// Only built when BRANCH_PREDICT_EN is defined.
`ifdef BRANCH_PREDICT_EN
module static_predictor
  import inst_fetch_queue_pkg::*;
(
  input  ins_t  i_inst,
  input  addr_t i_pc,
  output logic  o_pred,
  output addr_t o_next_pc
);

  always_comb begin
    o_pred    = 1'b0;
    o_next_pc = i_pc + 32'd4;
    if (opcode_of(i_inst) == OPCODE_JAL) begin
      o_pred    = 1'b1;
      o_next_pc = i_pc + j_imm(i_inst);
    end else if (opcode_of(i_inst) == OPCODE_BR && i_inst[31]) begin
      o_pred    = 1'b1;
      o_next_pc = i_pc + b_imm(i_inst);
    end
  end

endmodule
`endif

// File: rtl/inst_fetch_queue.sv
// Instruction fetch queue: one-outstanding fetch FSM feeding a circular buffer
// of {inst, pc[, pred]}. Static prediction enabled by BRANCH_PREDICT_EN.
module inst_fetch_queue
  import inst_fetch_queue_pkg::*;
#(
  parameter int    IQ_DEPTH = 16,
  parameter addr_t RESET_PC = 32'h0
) (
  input  logic                clk,
  input  logic                rst_n,
  inst_fetch_queue_if.master  bus
);

  localparam int PW = $clog2(IQ_DEPTH);
  localparam int CW = PW + 1;

  iq_state_e      r_state;
  addr_t          r_pc;
  addr_t          r_fetch_addr;
  logic           r_fetch_req;
  logic [PW-1:0]  r_head;
  logic [PW-1:0]  r_tail;
  logic [CW-1:0]  r_count;
  ins_t           r_inst_mem [IQ_DEPTH];
  addr_t          r_pc_mem   [IQ_DEPTH];

  logic  w_iq_valid;
  logic  w_live;
  logic  w_push;
  logic  w_pop;
  logic  w_issue;
  addr_t w_next_pc;

  assign w_iq_valid = (r_count != '0);
  assign w_live     = bus.rdy && !bus.rollback_en;
  assign w_push     = w_live && (r_state == IQ_BUSY) && bus.mem_inst_valid;
  assign w_pop      = w_live && bus.iq_pop && w_iq_valid;
  // Issuing only happens from IDLE, so no request is outstanding in this check.
  assign w_issue    = w_live && (r_state == IQ_IDLE) && (r_count < CW'(IQ_DEPTH));

`ifdef BRANCH_PREDICT_EN
  logic w_pred;
  logic r_pred_mem [IQ_DEPTH];

  static_predictor u_static_predictor (
    .i_inst    (bus.mem_inst),
    .i_pc      (r_pc),
    .o_pred    (w_pred),
    .o_next_pc (w_next_pc)
  );

  always_ff @(posedge clk) begin
    if (w_push) r_pred_mem[r_tail] <= w_pred;
  end

  assign bus.iq_pred_taken = w_iq_valid & r_pred_mem[r_head];
`else
  assign w_next_pc         = r_pc + 32'd4;
  assign bus.iq_pred_taken = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (w_push) begin
      r_inst_mem[r_tail] <= bus.mem_inst;
      r_pc_mem[r_tail]   <= r_pc;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= IQ_IDLE;
      r_pc         <= RESET_PC;
      r_fetch_addr <= ZERO_WORD;
      r_fetch_req  <= 1'b0;
      r_head       <= '0;
      r_tail       <= '0;
      r_count      <= '0;
    end else if (bus.rdy) begin
      r_fetch_req <= 1'b0;
      if (bus.rollback_en) begin
        r_head  <= '0;
        r_tail  <= '0;
        r_count <= '0;
        r_pc    <= bus.rollback_pc;
        // A response coinciding with the flush retires the outstanding request.
        if (r_state == IQ_IDLE || bus.mem_inst_valid) r_state <= IQ_IDLE;
        else                                          r_state <= IQ_DISCARD;
      end else begin
        case (r_state)
          IQ_IDLE: if (w_issue) begin
            r_fetch_req  <= 1'b1;
            r_fetch_addr <= r_pc;
            r_state      <= IQ_BUSY;
          end
          IQ_BUSY: if (bus.mem_inst_valid) begin
            r_tail  <= r_tail + PW'(1);
            r_pc    <= w_next_pc;
            r_state <= IQ_IDLE;
          end
          IQ_DISCARD: if (bus.mem_inst_valid) r_state <= IQ_IDLE;
          default: r_state <= IQ_IDLE;
        endcase
        if (w_pop) r_head <= r_head + PW'(1);
        case ({w_push, w_pop})
          2'b10:   r_count <= r_count + CW'(1);
          2'b01:   r_count <= r_count - CW'(1);
          default: r_count <= r_count;
        endcase
      end
    end
  end

  assign bus.fetch_req  = r_fetch_req & bus.rdy;
  assign bus.fetch_addr = r_fetch_addr;
  assign bus.iq_valid   = w_iq_valid;
  assign bus.iq_inst    = w_iq_valid ? r_inst_mem[r_head] : ZERO_WORD;
  assign bus.iq_pc      = w_iq_valid ? r_pc_mem[r_head]   : ZERO_WORD;

endmodule

// File: tb/tb_inst_fetch_queue.sv
// Directed bench for inst_fetch_queue with a 1-cycle memory model; predictor
// sequences are compiled in when BRANCH_PREDICT_EN is defined.
module tb_inst_fetch_queue;

  logic clk;
  logic rst_n;
  int   n_checks;
  int   n_fail;
  int   n_resp;
  logic pend;
  logic [31:0] pend_addr;

  inst_fetch_queue_if bus_if ();

  inst_fetch_queue #(.IQ_DEPTH(16), .RESET_PC(32'h0)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus_if)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        rdy;
    logic        pop;
    logic        fr;
    logic [31:0] fa;
    logic        v;
    logic [31:0] pc;
  } vec_t;

  vec_t tbl [18];

  function automatic vec_t mk(input logic rdy, input logic pop, input logic fr,
                              input logic [31:0] fa, input logic v, input logic [31:0] pc);
    vec_t r;
    r.rdy = rdy; r.pop = pop; r.fr = fr; r.fa = fa; r.v = v; r.pc = pc;
    return r;
  endfunction

  function automatic logic [31:0] word(input logic [31:0] a);
    case (a)
      32'h20:  return 32'h0400006F;   // jal x0, +0x40
      32'h30:  return 32'hFE001CE3;   // bne x0, x0, -8
      32'h34:  return 32'h00000863;   // beq x0, x0, +16
      default: return 32'h00000013 | (a << 7);
    endcase
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  // One clock: memory answers a request seen last cycle, then advance to the next negedge.
  task automatic tick();
    #1;
    if (bus_if.rdy) begin
      bus_if.mem_inst_valid = pend;
      bus_if.mem_inst       = pend ? word(pend_addr) : 32'h0;
      if (pend) n_resp++;
      pend      = bus_if.fetch_req;
      pend_addr = bus_if.fetch_addr;
    end else begin
      bus_if.mem_inst_valid = 1'b0;
    end
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic assert_reset();
    rst_n = 1'b0;
    bus_if.rdy = 1'b1; bus_if.iq_pop = 1'b0;
    bus_if.rollback_en = 1'b0; bus_if.rollback_pc = 32'h0;
    bus_if.mem_inst_valid = 1'b0; bus_if.mem_inst = 32'h0;
    pend = 1'b0; pend_addr = 32'h0; n_resp = 0;
    @(negedge clk);
    @(negedge clk);
  endtask

  task automatic do_reset();
    assert_reset();
    rst_n = 1'b1;
  endtask

  task automatic wait_req(input int max, output logic found, output logic [31:0] addr,
                          output logic saw_valid);
    found = 1'b0; addr = 32'h0; saw_valid = 1'b0;
    for (int i = 0; i < max && !found; i++) begin
      tick();
      if (bus_if.fetch_req) begin
        found = 1'b1;
        addr  = bus_if.fetch_addr;
      end else if (bus_if.iq_valid) begin
        saw_valid = 1'b1;
      end
    end
  endtask

  task automatic wait_valid(input int max, output logic found);
    found = 1'b0;
    for (int i = 0; i < max && !found; i++) begin
      tick();
      if (bus_if.iq_valid) found = 1'b1;
    end
  endtask

  task automatic rollback_to(input logic [31:0] pc);
    bus_if.rollback_en = 1'b1;
    bus_if.rollback_pc = pc;
    tick();
    bus_if.rollback_en = 1'b0;
  endtask

  initial begin
    logic        f;
    logic        sv;
    logic [31:0] a;
    int          nreq;
    logic [31:0] last_addr;
    n_checks = 0;
    n_fail   = 0;

    tbl[0]  = mk(1, 0, 1, 32'h00, 0, 32'h00);
    tbl[1]  = mk(1, 0, 0, 32'h00, 0, 32'h00);
    tbl[2]  = mk(1, 0, 0, 32'h00, 1, 32'h00);
    tbl[3]  = mk(1, 0, 1, 32'h04, 1, 32'h00);
    tbl[4]  = mk(1, 0, 0, 32'h04, 1, 32'h00);
    tbl[5]  = mk(1, 0, 0, 32'h04, 1, 32'h00);
    tbl[6]  = mk(1, 0, 1, 32'h08, 1, 32'h00);
    tbl[7]  = mk(1, 0, 0, 32'h08, 1, 32'h00);
    tbl[8]  = mk(0, 0, 0, 32'h08, 1, 32'h00);
    tbl[9]  = mk(0, 0, 0, 32'h08, 1, 32'h00);
    tbl[10] = mk(0, 0, 0, 32'h08, 1, 32'h00);
    tbl[11] = mk(1, 0, 0, 32'h08, 1, 32'h00);
    tbl[12] = mk(1, 1, 1, 32'h0C, 1, 32'h04);
    tbl[13] = mk(1, 1, 0, 32'h0C, 1, 32'h08);
    tbl[14] = mk(1, 1, 0, 32'h0C, 1, 32'h0C);
    tbl[15] = mk(1, 1, 1, 32'h10, 0, 32'h00);
    tbl[16] = mk(1, 1, 0, 32'h10, 0, 32'h00);
    tbl[17] = mk(1, 0, 0, 32'h10, 1, 32'h10);

    // Reset values observed while rst_n is held low
    assert_reset();
    chk("rst_fetch_req",  {31'h0, bus_if.fetch_req},     32'h0);
    chk("rst_fetch_addr", bus_if.fetch_addr,             32'h0);
    chk("rst_iq_valid",   {31'h0, bus_if.iq_valid},      32'h0);
    chk("rst_iq_inst",    bus_if.iq_inst,                32'h0);
    chk("rst_iq_pc",      bus_if.iq_pc,                  32'h0);
    chk("rst_iq_pred",    {31'h0, bus_if.iq_pred_taken}, 32'h0);
    rst_n = 1'b1;

    // Cycle-by-cycle fetch sequence with a 3-cycle rdy stall and pops
    for (int i = 0; i < 18; i++) begin
      bus_if.rdy    = tbl[i].rdy;
      bus_if.iq_pop = tbl[i].pop;
      tick();
      $display("vec %0d: rdy=%0d pop=%0d fetch_req=%0d fetch_addr=%h iq_valid=%0d iq_pc=%h",
               i, tbl[i].rdy, tbl[i].pop, bus_if.fetch_req, bus_if.fetch_addr,
               bus_if.iq_valid, bus_if.iq_pc);
      chk($sformatf("vec%0d_fetch_req", i),  {31'h0, bus_if.fetch_req}, {31'h0, tbl[i].fr});
      chk($sformatf("vec%0d_fetch_addr", i), bus_if.fetch_addr,         tbl[i].fa);
      chk($sformatf("vec%0d_iq_valid", i),   {31'h0, bus_if.iq_valid},  {31'h0, tbl[i].v});
      chk($sformatf("vec%0d_iq_pc", i),      bus_if.iq_pc,              tbl[i].pc);
      chk($sformatf("vec%0d_iq_inst", i),    bus_if.iq_inst,
          tbl[i].v ? word(tbl[i].pc) : 32'h0);
      chk($sformatf("vec%0d_iq_pred", i),    {31'h0, bus_if.iq_pred_taken}, 32'h0);
    end
    bus_if.iq_pop = 1'b0;

    // Fill with no pops: exactly IQ_DEPTH requests, then one pop buys one more
    do_reset();
    nreq = 0;
    last_addr = 32'h0;
    for (int i = 0; i < 80; i++) begin
      tick();
      if (bus_if.fetch_req) nreq++;
    end
    $display("fill: requests=%0d head_pc=%h", nreq, bus_if.iq_pc);
    chk("fill_requests", nreq, 16);
    chk("fill_count", 32'(dut.r_count), 32'd16);
    chk("fill_head_pc", bus_if.iq_pc, 32'h0);
    bus_if.iq_pop = 1'b1;
    tick();
    bus_if.iq_pop = 1'b0;
    if (bus_if.fetch_req) nreq++;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (bus_if.fetch_req) begin
        nreq++;
        last_addr = bus_if.fetch_addr;
      end
    end
    $display("refill: requests=%0d addr=%h", nreq, last_addr);
    chk("refill_requests", nreq, 17);
`ifdef BRANCH_PREDICT_EN
    chk("refill_addr", last_addr, 32'h7C);
`else
    chk("refill_addr", last_addr, 32'h40);
`endif
    chk("refill_head_pc", bus_if.iq_pc, 32'h4);

    // Push and pop in the same cycle with five entries held
    do_reset();
    for (int i = 0; i < 60 && n_resp < 5; i++) tick();
    chk("pp_reach5", n_resp, 5);
    for (int i = 0; i < 10 && !pend; i++) tick();
    chk("pp_pending", {31'h0, pend}, 32'h1);
    bus_if.iq_pop = 1'b1;
    tick();
    bus_if.iq_pop = 1'b0;
    $display("push+pop: count=%0d head=%0d tail=%0d iq_pc=%h",
             dut.r_count, dut.r_head, dut.r_tail, bus_if.iq_pc);
    chk("pp_count", 32'(dut.r_count), 32'd5);
    chk("pp_head",  32'(dut.r_head),  32'd1);
    chk("pp_tail",  32'(dut.r_tail),  32'd6);
    chk("pp_iq_pc", bus_if.iq_pc,     32'h4);

    // Rollback with a request outstanding; the stale response must be dropped
    wait_req(20, f, a, sv);
    chk("rb_pre_req_found", {31'h0, f}, 32'h1);
    chk("rb_pre_req_addr", a, 32'h18);
    rollback_to(32'h100);
    $display("rollback: iq_valid=%0d fetch_req=%0d", bus_if.iq_valid, bus_if.fetch_req);
    chk("rb_empty", {31'h0, bus_if.iq_valid}, 32'h0);
    chk("rb_no_req", {31'h0, bus_if.fetch_req}, 32'h0);
    wait_req(20, f, a, sv);
    chk("rb_req_found", {31'h0, f}, 32'h1);
    chk("rb_req_addr", a, 32'h100);
    chk("rb_stale_dropped", {31'h0, sv}, 32'h0);
    wait_valid(20, f);
    $display("rollback refill: iq_pc=%h iq_inst=%h", bus_if.iq_pc, bus_if.iq_inst);
    chk("rb_valid_found", {31'h0, f}, 32'h1);
    chk("rb_iq_pc", bus_if.iq_pc, 32'h100);
    chk("rb_iq_inst", bus_if.iq_inst, word(32'h100));
    wait_req(20, f, a, sv);
    chk("rb_next_addr", a, 32'h104);
    chk("rb_count", 32'(dut.r_count), 32'd1);

`ifdef BRANCH_PREDICT_EN
    // Static prediction: JAL taken, backward branch taken, forward branch not
    do_reset();
    rollback_to(32'h20);
    wait_req(20, f, a, sv);
    chk("jal_fetch", a, 32'h20);
    wait_req(20, f, a, sv);
    $display("jal: next=%h iq_pc=%h pred=%0d", a, bus_if.iq_pc, bus_if.iq_pred_taken);
    chk("jal_next", a, 32'h60);
    chk("jal_iq_pc", bus_if.iq_pc, 32'h20);
    chk("jal_pred", {31'h0, bus_if.iq_pred_taken}, 32'h1);
    rollback_to(32'h30);
    wait_req(20, f, a, sv);
    chk("bne_fetch", a, 32'h30);
    wait_req(20, f, a, sv);
    $display("bne: next=%h iq_pc=%h pred=%0d", a, bus_if.iq_pc, bus_if.iq_pred_taken);
    chk("bne_next", a, 32'h28);
    chk("bne_iq_pc", bus_if.iq_pc, 32'h30);
    chk("bne_pred", {31'h0, bus_if.iq_pred_taken}, 32'h1);
    rollback_to(32'h34);
    wait_req(20, f, a, sv);
    chk("beq_fetch", a, 32'h34);
    wait_req(20, f, a, sv);
    $display("beq: next=%h iq_pc=%h pred=%0d", a, bus_if.iq_pc, bus_if.iq_pred_taken);
    chk("beq_next", a, 32'h38);
    chk("beq_iq_pc", bus_if.iq_pc, 32'h34);
    chk("beq_pred", {31'h0, bus_if.iq_pred_taken}, 32'h0);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
